seven_segment_bank_controller: RTL and testbench

Memory-mapped, parametrised hex display controller on the CPU I/O bus (`mio == 0`). It drives `DIGITS` static seven-segment digits from nibble registers. Beyond plain hex display, it adds per-digit blinking, leading-zero suppression, global blanking and register read-back. It replaces the fixed four-digit write-only controller.

---
 rtl/seven_segment_bank_controller.sv | 199 +++++++++++++++++++
 tb/tb_seven_segment_bank_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_bank_controller.sv
// seven_segment_bank_controller
//
// Memory-mapped hex display controller on the CPU I/O bus (mio == 0).
// Drives DIGITS static seven-segment digits from nibble registers, with
// per-digit blinking, leading-zero suppression, global blanking and
// register read-back.
//
// Register map (byte offsets from BASE_ADDRESS):
//   0 .. DIGITS/2-1 : DATA[i]    low nibble = digit 2i, high nibble = digit 2i+1
//   8               : CONTROL    bit0 display on, bit1 leading-zero suppress
//   9               : BLINK_MASK bit k = digit k blinks
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   asynchronous, active-low
//   addressBus  in   32-bit byte address, fully decoded
//   dataBusIn   in   8-bit write data
//   dataBusOut  out  8-bit registered read data (holds between reads)
//   readWrite   in   1 = read, 0 = write
//   mio         in   0 = I/O cycle (served), 1 = memory cycle (ignored)
//   enable      in   bus cycle strobe
//   segments    out  7*DIGITS, digit k at [7k+6:7k], bit order g..a, active-low
module seven_segment_bank_controller #(
  parameter int          DIGITS        = 4,
  parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0100,
  parameter int          BLINK_DIVIDER = 25_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           addressBus,
  input  logic [7:0]            dataBusIn,
  output logic [7:0]            dataBusOut,
  input  logic                  readWrite,
  input  logic                  mio,
  input  logic                  enable,
  output logic [7*DIGITS-1:0]   segments
);

  localparam int BYTES = DIGITS / 2;
  localparam int CW    = (BLINK_DIVIDER > 1) ? $clog2(BLINK_DIVIDER) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIVIDER - 1);

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic             io_cycle;
  logic             wr_en;
  logic             rd_en;
  logic [BYTES-1:0] data_hit;
  logic             ctrl_hit;
  logic             mask_hit;

  assign io_cycle = enable && !mio;
  assign wr_en    = io_cycle && !readWrite;
  assign rd_en    = io_cycle && readWrite;
  assign ctrl_hit = (addressBus == BASE_ADDRESS + 32'd8);
  assign mask_hit = (addressBus == BASE_ADDRESS + 32'd9);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_data_hit
      assign data_hit[gi] = (addressBus == BASE_ADDRESS + 32'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [7:0]        data_reg [BYTES];
  logic [1:0]        ctrl_reg;
  logic [DIGITS-1:0] mask_reg;
  logic [7:0]        dout_reg;
  logic [7:0]        dout_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BYTES; i++) begin
        data_reg[i] <= 8'h00;
      end
      ctrl_reg <= 2'b01;
      mask_reg <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (data_hit[i]) begin
          data_reg[i] <= dataBusIn;
        end
      end
      if (ctrl_hit) begin
        ctrl_reg <= dataBusIn[1:0];
      end
      if (mask_hit) begin
        // Mask bits for digits that do not exist are dropped.
        mask_reg <= dataBusIn[DIGITS-1:0];
      end
    end
  end

  // Read mux: unmapped offsets return zero, unused CONTROL/MASK bits read 0.
  always_comb begin
    dout_next = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      if (data_hit[i]) begin
        dout_next = data_reg[i];
      end
    end
    if (ctrl_hit) begin
      dout_next = {6'b000000, ctrl_reg};
    end
    if (mask_hit) begin
      for (int k = 0; k < DIGITS; k++) begin
        dout_next[k] = mask_reg[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout_reg <= 8'h00;
    end else if (rd_en) begin
      dout_reg <= dout_next;
    end
  end

  assign dataBusOut = dout_reg;

  // ---------------------------------------------------------------------
  // Blink timer: free-running, never disturbed by control or mask writes.
  // ---------------------------------------------------------------------
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          phase_reg;
  logic          phase_next;
  logic          cnt_wrap;

  assign cnt_wrap   = (cnt_reg == CNT_MAX);
  assign cnt_next   = cnt_wrap ? '0 : cnt_reg + 1'b1;
  assign phase_next = phase_reg ^ cnt_wrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  // ---------------------------------------------------------------------
  // Segment generation
  // ---------------------------------------------------------------------
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [3:0]      digit_nib [DIGITS];
  // zero_from[k] is set when digits DIGITS-1 down to k are all zero.
  logic [DIGITS:1] zero_from;
  logic [DIGITS-1:0] blank;

  assign zero_from[DIGITS] = 1'b1;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_nib[gi] = data_reg[gi / 2][4 * (gi % 2) +: 4];

      if (gi == 0) begin : g_first
        // Digit 0 is never suppressed so a zero value still shows "0".
        assign blank[gi] = !ctrl_reg[0] || (mask_reg[gi] && phase_reg);
      end else begin : g_rest
        assign zero_from[gi] = (digit_nib[gi] == 4'h0) && zero_from[gi + 1];
        assign blank[gi] = !ctrl_reg[0] || (mask_reg[gi] && phase_reg) ||
                           (ctrl_reg[1] && zero_from[gi]);
      end

      assign segments[7 * gi +: 7] = blank[gi] ? 7'h7F : hex_glyph(digit_nib[gi]);
    end
  endgenerate

endmodule

// File: tb/tb_seven_segment_bank_controller.sv
// Testbench for seven_segment_bank_controller (DIGITS = 4, BLINK_DIVIDER = 4).
// A behavioural model of the register file and blink phase is checked against
// the DUT on every falling clock edge; directed checks with hand-computed
// literals pin the model.
module tb_seven_segment_bank_controller;

  localparam int          DIGITS = 4;
  localparam int          DIV    = 4;
  localparam logic [31:0] BASE   = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rw;
  logic        mio;
  logic        enable;
  logic [27:0] segments;

  int tests = 0;
  int fails = 0;

  seven_segment_bank_controller #(
    .DIGITS(DIGITS),
    .BASE_ADDRESS(BASE),
    .BLINK_DIVIDER(DIV)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .addressBus(addr),
    .dataBusIn(din),
    .dataBusOut(dout),
    .readWrite(rw),
    .mio(mio),
    .enable(enable),
    .segments(segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         m_cycles;
  logic [7:0] m_data [2];
  logic [7:0] m_ctrl;
  logic [7:0] m_mask;
  logic [7:0] m_dout;

  function automatic logic [7:0] model_read(input logic [31:0] a);
    if (a == BASE)              return m_data[0];
    else if (a == BASE + 32'd1) return m_data[1];
    else if (a == BASE + 32'd8) return m_ctrl;
    else if (a == BASE + 32'd9) return m_mask;
    else                        return 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cycles  <= 0;
      m_data[0] <= 8'h00;
      m_data[1] <= 8'h00;
      m_ctrl    <= 8'h01;
      m_mask    <= 8'h00;
      m_dout    <= 8'h00;
    end else begin
      m_cycles <= m_cycles + 1;
      if (enable && !mio) begin
        if (rw) begin
          m_dout <= model_read(addr);
        end else if (addr == BASE)              m_data[0] <= din;
        else if (addr == BASE + 32'd1)          m_data[1] <= din;
        else if (addr == BASE + 32'd8)          m_ctrl    <= din & 8'h03;
        else if (addr == BASE + 32'd9)          m_mask    <= din & 8'h0F;
      end
    end
  end

  function automatic logic [27:0] model_segments();
    logic [27:0] r;
    logic [6:0]  g;
    int          value;
    int          phase;
    value = int'({m_data[1], m_data[0]});
    phase = (m_cycles / DIV) % 2;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!m_ctrl[0])                                  g = 7'h7F;
      else if (m_mask[k] && phase == 1)                g = 7'h7F;
      else if (m_ctrl[1] && k > 0 && (value >> (4 * k)) == 0) g = 7'h7F;
      else                                             g = glyph_tab[(value >> (4 * k)) & 15];
      r[7 * k +: 7] = g;
    end
    return r;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    tests++;
    if (segments !== model_segments()) begin
      fails++;
      $display("FAIL model_segments t=%0t: segments=%h expected=%h", $time, segments, model_segments());
    end
    tests++;
    if (dout !== m_dout) begin
      fails++;
      $display("FAIL model_dout t=%0t: dataBusOut=%h expected=%h", $time, dout, m_dout);
    end
  end

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  function automatic logic [27:0] seg4(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check_seg(input string name, input logic [27:0] exp);
    tests++;
    if (segments !== exp) begin
      fails++;
      $display("FAIL %s: segments=%h expected=%h", name, segments, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d, input logic m);
    addr = a; din = d; rw = 1'b0; mio = m; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; mio = 1'b0;
    $display("[TB] write addr=%h data=%h mio=%0b segments=%h", a, d, m, segments);
  endtask

  task automatic bus_read(input logic [31:0] a);
    addr = a; rw = 1'b1; mio = 1'b0; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    $display("[TB] read  addr=%h data=%h", a, dout);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; enable = 1'b0; mio = 1'b0; rw = 1'b1; addr = '0; din = '0;
    idle(2);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_seg("reset_segments", seg4(7'h40, 7'h40, 7'h40, 7'h40));
    check8("reset_dout", dout, 8'h00);
    bus_read(BASE + 32'd8);
    check8("reset_control", dout, 8'h01);

    // Data writes
    bus_write(BASE, 8'h3A, 1'b0);
    bus_write(BASE + 32'd1, 8'hF1, 1'b0);
    check_seg("data_write", seg4(7'h0E, 7'h79, 7'h30, 7'h08));
    bus_write(BASE, 8'h55, 1'b1);
    bus_write(BASE + 32'd1, 8'h55, 1'b1);
    check_seg("mio_ignored", seg4(7'h0E, 7'h79, 7'h30, 7'h08));
    bus_write(BASE + 32'd5, 8'h55, 1'b0);
    check_seg("unmapped_write", seg4(7'h0E, 7'h79, 7'h30, 7'h08));
    bus_read(BASE + 32'd5);
    check8("unmapped_read", dout, 8'h00);
    bus_write(32'h8000_0100, 8'h55, 1'b0);
    check_seg("full_decode", seg4(7'h0E, 7'h79, 7'h30, 7'h08));
    bus_read(BASE);
    check8("read_data0", dout, 8'h3A);
    bus_read(BASE + 32'd1);
    check8("read_data1", dout, 8'hF1);

    // Suppression
    bus_write(BASE, 8'h05, 1'b0);
    bus_write(BASE + 32'd1, 8'h00, 1'b0);
    bus_write(BASE + 32'd8, 8'h03, 1'b0);
    bus_read(BASE + 32'd8);
    check8("read_after_write_ctrl", dout, 8'h03);
    check_seg("suppress_05", seg4(7'h7F, 7'h7F, 7'h7F, 7'h12));
    bus_write(BASE + 32'd1, 8'h10, 1'b0);
    check_seg("suppress_inner_zero", seg4(7'h79, 7'h40, 7'h40, 7'h12));
    bus_write(BASE + 32'd1, 8'h00, 1'b0);
    bus_write(BASE, 8'h00, 1'b0);
    check_seg("suppress_all_zero", seg4(7'h7F, 7'h7F, 7'h7F, 7'h40));
    bus_write(BASE + 32'd8, 8'h00, 1'b0);
    check_seg("display_off", seg4(7'h7F, 7'h7F, 7'h7F, 7'h7F));

    // Reset asserted during a write: access discarded
    addr = BASE; din = 8'h77; rw = 1'b0; mio = 1'b0; enable = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_seg("reset_mid_cycle_seg", seg4(7'h40, 7'h40, 7'h40, 7'h40));
    check8("reset_mid_cycle_dout", dout, 8'h00);
    @(negedge clk);
    enable = 1'b0;
    #2 rst_n = 1'b1;

    // Blink timing: edges counted from reset release
    bus_write(BASE, 8'h3A, 1'b0);            // edge 1
    bus_write(BASE + 32'd1, 8'hF1, 1'b0);    // edge 2
    bus_write(BASE + 32'd9, 8'h02, 1'b0);    // edge 3
    check_seg("blink_on_e3", seg4(7'h0E, 7'h79, 7'h30, 7'h08));
    idle(1);                                 // edge 4: first toggle
    check_seg("blink_off_e4", seg4(7'h0E, 7'h79, 7'h7F, 7'h08));
    idle(3);                                 // edge 7
    check_seg("blink_off_e7", seg4(7'h0E, 7'h79, 7'h7F, 7'h08));
    idle(1);                                 // edge 8
    check_seg("blink_on_e8", seg4(7'h0E, 7'h79, 7'h30, 7'h08));
    bus_write(BASE + 32'd9, 8'h00, 1'b0);    // edge 9
    bus_write(BASE + 32'd9, 8'hF2, 1'b0);    // edge 10
    idle(1);                                 // edge 11
    check_seg("blink_on_e11", seg4(7'h0E, 7'h79, 7'h30, 7'h08));
    idle(1);                                 // edge 12: toggle unshifted
    check_seg("blink_off_e12", seg4(7'h0E, 7'h79, 7'h7F, 7'h08));
    idle(10);

    // Read-back
    bus_read(BASE + 32'd9);
    check8("read_mask", dout, 8'h02);
    bus_read(BASE + 32'd8);
    check8("read_ctrl", dout, 8'h01);
    bus_read(BASE);
    check8("read_data0_b", dout, 8'h3A);
    bus_read(BASE + 32'd2);
    check8("read_offset2_unmapped", dout, 8'h00);
    idle(2);
    check8("dout_holds", dout, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
